// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   XLEN          default PC / immediate width
//   ILEN          instruction width
//   NOP_INSTR     canonical nop (addi x0,x0,0), shown in the instruction slot after reset
//   fetch_state_t fetch FSM states
package cpu_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    RESET = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;
endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection for the fetch unit (purely combinational).
//   instr_pc   in   PC of the instruction being consumed
//   br_taken   in   consumed instruction redirects to instr_pc + br_imm
//   br_imm     in   sign-extended immediate
//   flush      in   external redirect, highest priority
//   flush_pc   in   external redirect target
//   next_pc    out  selected next fetch PC (modulo 2^XLEN)
//   misaligned out  next_pc is not word aligned
module fetch_pc_next
  import cpu_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [W-1:0] instr_pc,
  input  logic         br_taken,
  input  logic [W-1:0] br_imm,
  input  logic         flush,
  input  logic [W-1:0] flush_pc,
  output logic [W-1:0] next_pc,
  output logic         misaligned
);

  localparam logic [W-1:0] STEP = W'(4);

  always_comb begin
    if (flush)
      next_pc = flush_pc;
    else if (br_taken)
      next_pc = instr_pc + br_imm;
    else
      next_pc = instr_pc + STEP;
    misaligned = (next_pc[1:0] != 2'b00);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds one instruction for decode and redirects on branch or flush.
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     fetch request and address (held until imem_ack)
//   imem_ack/rdata    memory response
//   instr/instr_pc    held instruction and its PC, qualified by instr_valid
//   instr_ready       decode consumes the held instruction
//   br_taken/br_imm   branch outcome of the consumed instruction
//   flush/flush_pc    external redirect
//   fetch_fault       sticky misaligned-target indication
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_imm,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            fetch_fault
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [31:0]     instr_reg, instr_next;
  logic [XLEN-1:0] instr_pc_reg, instr_pc_next;
  logic            valid_reg, valid_next;
  logic            fault_reg, fault_next;
  // Redirect target remembered while an aborted request drains.
  logic [XLEN-1:0] drain_pc_reg, drain_pc_next;
  logic            drain_mis_reg, drain_mis_next;

  logic [XLEN-1:0] sel_pc;
  logic            sel_mis;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_mis;

  fetch_pc_next #(.W(XLEN)) u_pc_next (
    .instr_pc   (instr_pc_reg),
    .br_taken   (br_taken),
    .br_imm     (br_imm),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .next_pc    (sel_pc),
    .misaligned (sel_mis)
  );

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    instr_pc_next  = instr_pc_reg;
    valid_next     = valid_reg;
    fault_next     = fault_reg;
    drain_pc_next  = drain_pc_reg;
    drain_mis_next = drain_mis_reg;
    redirect       = 1'b0;
    redirect_pc    = sel_pc;
    redirect_mis   = sel_mis;

    case (state_reg)
      RESET: begin
        if (flush) redirect = 1'b1;
        else       state_next = REQ;
      end
      REQ: begin
        if (flush) begin
          if (imem_ack) begin
            redirect = 1'b1;               // returned word is discarded
          end else begin
            // The handshake must complete, so park the target until ack.
            state_next     = DRAIN;
            drain_pc_next  = flush_pc;
            drain_mis_next = sel_mis;
          end
        end else if (imem_ack) begin
          instr_next    = imem_rdata;
          instr_pc_next = pc_reg;
          valid_next    = 1'b1;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        // Flush wins over consume; sel_pc already reflects that priority.
        if (flush || instr_ready) begin
          valid_next = 1'b0;
          redirect   = 1'b1;
        end
      end
      DRAIN: begin
        if (flush && !imem_ack) begin
          drain_pc_next  = flush_pc;
          drain_mis_next = sel_mis;
        end else if (flush) begin
          redirect = 1'b1;
        end else if (imem_ack) begin
          redirect     = 1'b1;
          redirect_pc  = drain_pc_reg;
          redirect_mis = drain_mis_reg;
        end
      end
      FAULT: begin
        if (flush && !sel_mis) redirect = 1'b1;
      end
      default: state_next = RESET;
    endcase

    if (redirect) begin
      pc_next = redirect_pc;
      if (redirect_mis) begin
        state_next = FAULT;
        fault_next = 1'b1;
      end else begin
        state_next = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RESET;
      pc_reg        <= RESET_PC;
      instr_reg     <= NOP_INSTR;
      instr_pc_reg  <= '0;
      valid_reg     <= 1'b0;
      fault_reg     <= 1'b0;
      drain_pc_reg  <= '0;
      drain_mis_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      instr_pc_reg  <= instr_pc_next;
      valid_reg     <= valid_next;
      fault_reg     <= fault_next;
      drain_pc_reg  <= drain_pc_next;
      drain_mis_reg <= drain_mis_next;
    end
  end

  // pc is not updated until a drain completes, so imem_addr keeps the old address.
  assign imem_req    = (state_reg == REQ) || (state_reg == DRAIN);
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = valid_reg;
  assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [63:0] br_imm;
  logic        flush;
  logic [63:0] flush_pc;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_taken    (br_taken),
    .br_imm      (br_imm),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers (all drive on the negative edge; outputs sampled there too).
  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL %s_req_timeout got imem_req=%b want 1", tag, imem_req);
    end
  endtask

  task automatic do_ack(input int delay, input logic [31:0] data);
    for (int i = 0; i < delay; i++) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAD0BAD0;
  endtask

  task automatic consume(input logic taken, input logic [63:0] imm);
    instr_ready = 1'b1;
    br_taken    = taken;
    br_imm      = imm;
    @(negedge clk);
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_imm      = '0;
  endtask

  task automatic do_flush(input logic [63:0] target);
    flush    = 1'b1;
    flush_pc = target;
    @(negedge clk);
    flush    = 1'b0;
    flush_pc = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({imem_req, instr_valid, fetch_fault} !== 3'b000 || imem_addr !== 64'h0 ||
        instr !== 32'h00000013 || instr_pc !== 64'h0) begin
      bad++;
      $display("FAIL reset_state got req=%b v=%b f=%b addr=%h instr=%h ipc=%h want 0 0 0 0 00000013 0",
               imem_req, instr_valid, fetch_fault, imem_addr, instr, instr_pc);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      bad++;
      $display("FAIL first_req got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    $display("reset: first request at %h", imem_addr);
  endtask

  task automatic test_sequential;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_req("seq");
      total++;
      if (imem_addr !== 64'(4 * k)) begin
        bad++;
        $display("FAIL seq_addr got %h want %h", imem_addr, 64'(4 * k));
      end
      do_ack(2, 32'h00A00093);
      if (k == 2) instr_ready = 1'b0;
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 64'(4 * k) || instr !== 32'h00A00093) begin
        bad++;
        $display("FAIL seq_instr got v=%b pc=%h instr=%h want 1 %h 00a00093",
                 instr_valid, instr_pc, instr, 64'(4 * k));
      end
      $display("seq: fetched pc=%h instr=%h", instr_pc, instr);
    end
  endtask

  task automatic test_branch;
    do_flush(64'h100);
    wait_req("br");
    do_ack(0, 32'h00000063);
    consume(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'hF8 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL br_taken got req=%b addr=%h v=%b want 1 f8 0", imem_req, imem_addr, instr_valid);
    end
    $display("branch taken: next addr=%h", imem_addr);
    do_ack(1, 32'h00000013);
    do_flush(64'h100);
    wait_req("br2");
    do_ack(0, 32'h00000063);
    consume(1'b0, 64'hFFFF_FFFF_FFFF_FFF8);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h104) begin
      bad++;
      $display("FAIL br_not_taken got req=%b addr=%h want 1 104", imem_req, imem_addr);
    end
    $display("branch not taken: next addr=%h", imem_addr);
    do_ack(0, 32'h00000013);
  endtask

  task automatic test_flush_drain;
    consume(1'b0, 64'h0);
    do_flush(64'h2000);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h108) begin
      bad++;
      $display("FAIL drain_hold got req=%b addr=%h want 1 108", imem_req, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
        bad++;
        $display("FAIL drain_wait got v=%b req=%b want 0 1", instr_valid, imem_req);
      end
    end
    do_ack(0, 32'hDEADBEEF);
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
      bad++;
      $display("FAIL drain_done got v=%b req=%b addr=%h want 0 1 2000", instr_valid, imem_req, imem_addr);
    end
    do_ack(0, 32'h11111111);
    total++;
    if (instr_valid !== 1'b1 || instr !== 32'h11111111 || instr_pc !== 64'h2000) begin
      bad++;
      $display("FAIL drain_refetch got v=%b instr=%h pc=%h want 1 11111111 2000", instr_valid, instr, instr_pc);
    end
    $display("flush/drain: refetched pc=%h instr=%h", instr_pc, instr);
  endtask

  task automatic test_fault;
    do_flush(64'h10);
    wait_req("flt");
    do_ack(0, 32'h00600063);
    consume(1'b1, 64'h6);
    total++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL fault_enter got f=%b req=%b v=%b want 1 0 0", fetch_fault, imem_req, instr_valid);
    end
    do_flush(64'h42);
    @(negedge clk);
    total++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL fault_bad_flush got f=%b req=%b want 1 0", fetch_fault, imem_req);
    end
    do_flush(64'h40);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h40) begin
      bad++;
      $display("FAIL fault_recover got req=%b addr=%h want 1 40", imem_req, imem_addr);
    end
    do_ack(0, 32'h00000013);
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 64'h40) begin
      bad++;
      $display("FAIL fault_refetch got v=%b pc=%h want 1 40", instr_valid, instr_pc);
    end
    $display("fault: recovered at pc=%h", instr_pc);
  endtask

  task automatic test_stall_wrap;
    do_flush(64'hFFFF_FFFF_FFFF_FFFC);
    wait_req("wrap");
    do_ack(1, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      imem_rdata = 32'hCAFE0000 + 32'(i);
      total++;
      if (instr_valid !== 1'b1 || instr !== 32'h12345678 || instr_pc !== 64'hFFFF_FFFF_FFFF_FFFC ||
          imem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold got v=%b instr=%h pc=%h req=%b want 1 12345678 fffffffffffffffc 0",
                 instr_valid, instr, instr_pc, imem_req);
      end
      @(negedge clk);
    end
    consume(1'b0, 64'h0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      bad++;
      $display("FAIL wrap_addr got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    $display("wrap: next addr=%h", imem_addr);
    do_ack(0, 32'h00000013);
  endtask

  task automatic test_async_reset;
    consume(1'b0, 64'h0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({imem_req, instr_valid, fetch_fault} !== 3'b000 || imem_addr !== 64'h0 ||
        instr !== 32'h00000013 || instr_pc !== 64'h0) begin
      bad++;
      $display("FAIL async_reset got req=%b v=%b f=%b addr=%h instr=%h ipc=%h want 0 0 0 0 00000013 0",
               imem_req, instr_valid, fetch_fault, imem_addr, instr, instr_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      bad++;
      $display("FAIL restart got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    $display("async reset: restart addr=%h", imem_addr);
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    br_taken    = 1'b0;
    br_imm      = '0;
    flush       = 1'b0;
    flush_pc    = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_flush_drain();
    test_fault();
    test_stall_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
